// File: rtl/raggedstone_spinn_aer_if_ctrl_pkg.sv
// Shared definitions for the SpiNNaker <-> AER interface control-packet path:
// packet field layout, command/select codes, FSM states and the default reply key.
package raggedstone_spinn_aer_if_ctrl_pkg;

  localparam int unsigned PKT_BITS   = 72;
  localparam int unsigned HDR_LSB    = 0;
  localparam int unsigned HDR_MSB    = 7;
  localparam int unsigned HDR_PP_BIT = 1;
  localparam int unsigned KEY_LSB    = 8;
  localparam int unsigned KEY_MSB    = 39;
  localparam int unsigned PLD_LSB    = 40;
  localparam int unsigned PLD_MSB    = 71;
  localparam int unsigned CMD_LSB    = 0;
  localparam int unsigned CMD_MSB    = 3;

  localparam logic [31:0] DEFAULT_REPLY_KEY = 32'hFFFF_FE00;

  typedef enum logic [3:0] {
    CMD_WR_VKEY = 4'h0,
    CMD_WR_MODE = 4'h1,
    CMD_WR_EN   = 4'h2,
    CMD_RD      = 4'h3
  } cmd_e;

  typedef enum logic [1:0] {
    SEL_VKEY = 2'd0,
    SEL_MODE = 2'd1,
    SEL_EN   = 2'd2,
    SEL_ERR  = 2'd3
  } rd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_REPLY
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == '1) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/raggedstone_spinn_aer_if_parity.sv
// Combinational odd-parity generator: the output makes the total number of ones
// across the 71 input bits plus the parity bit odd.
module raggedstone_spinn_aer_if_parity (
  input  logic [70:0] data,
  output logic        parity
);

  assign parity = ~^data;

endmodule

// File: rtl/raggedstone_spinn_aer_if_ctrl.sv
// Control-packet controller: decodes commands from router control packets, updates
// the interface configuration registers and returns read data as reply packets.
module raggedstone_spinn_aer_if_ctrl
  import raggedstone_spinn_aer_if_ctrl_pkg::*;
#(
  parameter logic [31:0] VKEY_RST  = 32'h0200_0000,
  parameter logic [3:0]  MODE_RST  = 4'h0,
  parameter logic [31:0] REPLY_KEY = DEFAULT_REPLY_KEY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PKT_BITS-1:0] cpkt_data,
  input  logic                cpkt_vld,
  output logic                cpkt_rdy,
  output logic [PKT_BITS-1:0] rpkt_data,
  output logic                rpkt_vld,
  input  logic                rpkt_rdy,
  output logic [31:0]         vkey,
  output logic [3:0]          mode,
  output logic                enable,
  output logic [7:0]          err_cnt,
  output logic                busy
);

  state_e      state, state_nxt;
  logic [3:0]  cmd_q;
  logic [31:0] pld_q;
  logic        pp_q;
  logic        cmd_ok;
  logic        is_rd;
  logic [31:0] rd_data;
  logic [31:0] reply_key;
  logic [70:0] reply_body;
  logic        reply_par;

  assign cmd_ok = pp_q && (cmd_q <= CMD_RD);
  assign is_rd  = cmd_ok && (cmd_q == CMD_RD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Ready is gated by reset so the router sees back-pressure while held in reset.
  always_comb begin
    state_nxt = state;
    cpkt_rdy  = 1'b0;
    rpkt_vld  = 1'b0;
    busy      = 1'b1;
    unique case (state)
      ST_IDLE: begin
        cpkt_rdy = rst;
        busy     = 1'b0;
        if (cpkt_vld && rst) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = is_rd ? ST_REPLY : ST_IDLE;
      end
      ST_REPLY: begin
        rpkt_vld = 1'b1;
        if (rpkt_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q <= '0;
      pld_q <= '0;
      pp_q  <= 1'b0;
    end else if (state == ST_IDLE && cpkt_vld) begin
      cmd_q <= cpkt_data[KEY_LSB+CMD_MSB:KEY_LSB+CMD_LSB];
      pld_q <= cpkt_data[PLD_MSB:PLD_LSB];
      pp_q  <= cpkt_data[HDR_LSB+HDR_PP_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vkey    <= VKEY_RST;
      mode    <= MODE_RST;
      enable  <= 1'b0;
      err_cnt <= '0;
    end else if (state == ST_EXEC) begin
      if (!cmd_ok) begin
        err_cnt <= sat_inc8(err_cnt);
      end else begin
        case (cmd_q)
          CMD_WR_VKEY: vkey   <= pld_q;
          CMD_WR_MODE: mode   <= pld_q[3:0];
          CMD_WR_EN:   enable <= pld_q[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel_e'(pld_q[1:0]))
      SEL_VKEY: rd_data = vkey;
      SEL_MODE: rd_data = {28'b0, mode};
      SEL_EN:   rd_data = {31'b0, enable};
      SEL_ERR:  rd_data = {24'b0, err_cnt};
      default:  rd_data = '0;
    endcase
  end

  assign reply_key  = REPLY_KEY | {28'b0, CMD_RD};
  assign reply_body = {rd_data, reply_key, 6'b0, 1'b1};

  raggedstone_spinn_aer_if_parity u_parity (
    .data   (reply_body),
    .parity (reply_par)
  );

  // Reply is registered in EXEC and held untouched for the whole REPLY state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          rpkt_data <= '0;
    else if (state == ST_EXEC && is_rd) rpkt_data <= {reply_body, reply_par};
  end

endmodule

// File: tb/tb_raggedstone_spinn_aer_if_ctrl.sv
// Directed self-checking bench for raggedstone_spinn_aer_if_ctrl.
module tb_raggedstone_spinn_aer_if_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] cpkt_data;
  logic        cpkt_vld;
  logic        cpkt_rdy;
  logic [71:0] rpkt_data;
  logic        rpkt_vld;
  logic        rpkt_rdy;
  logic [31:0] vkey;
  logic [3:0]  mode;
  logic        enable;
  logic [7:0]  err_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  raggedstone_spinn_aer_if_ctrl #(
    .VKEY_RST  (32'h0200_0000),
    .MODE_RST  (4'h0),
    .REPLY_KEY (32'hFFFF_FE00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpkt_data (cpkt_data),
    .cpkt_vld  (cpkt_vld),
    .cpkt_rdy  (cpkt_rdy),
    .rpkt_data (rpkt_data),
    .rpkt_vld  (rpkt_vld),
    .rpkt_rdy  (rpkt_rdy),
    .vkey      (vkey),
    .mode      (mode),
    .enable    (enable),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic [3:0] cmd, input logic pp, input logic [31:0] pld);
    return {pld, 28'h0000_FFF, cmd, 6'b0, pp, 1'b0};
  endfunction

  // Presents a packet and holds it until the handshake edge; returns 1 time unit after it.
  task automatic send(input logic [71:0] p);
    int unsigned n = 0;
    cpkt_data = p;
    cpkt_vld  = 1'b1;
    while (!cpkt_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", {71'b0, n < 20}, 72'd1);
    @(posedge clk);
    #1;
    cpkt_vld  = 1'b0;
    cpkt_data = 'x;
  endtask

  initial begin
    rst       = 1'b0;
    cpkt_vld  = 1'b0;
    cpkt_data = '0;
    rpkt_rdy  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cpkt_rdy", {71'b0, cpkt_rdy}, 72'd0);
    chk("rst_rpkt_vld", {71'b0, rpkt_vld}, 72'd0);
    chk("rst_rpkt_data", rpkt_data, 72'd0);
    chk("rst_busy", {71'b0, busy}, 72'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_cpkt_rdy", {71'b0, cpkt_rdy}, 72'd1);
    chk("post_rst_vkey", {40'b0, vkey}, 72'h0200_0000);
    chk("post_rst_mode", {68'b0, mode}, 72'd0);
    chk("post_rst_enable", {71'b0, enable}, 72'd0);
    chk("post_rst_err", {64'b0, err_cnt}, 72'd0);
    @(negedge clk);

    // WR_VKEY: visible one edge after the handshake, no reply
    send(mk(4'h0, 1'b1, 32'h1234_5678));
    @(negedge clk);
    chk("wrvkey_exec_vkey_old", {40'b0, vkey}, 72'h0200_0000);
    chk("wrvkey_exec_busy", {71'b0, busy}, 72'd1);
    chk("wrvkey_exec_rdy", {71'b0, cpkt_rdy}, 72'd0);
    @(negedge clk);
    chk("wrvkey_vkey", {40'b0, vkey}, 72'h1234_5678);
    chk("wrvkey_no_reply", {71'b0, rpkt_vld}, 72'd0);

    // RD vkey with reply back-pressure for 5 cycles
    send(mk(4'h3, 1'b1, 32'h0000_0000));
    @(negedge clk);
    chk("rd0_exec_vld", {71'b0, rpkt_vld}, 72'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd0_hold_vld", {71'b0, rpkt_vld}, 72'd1);
      chk("rd0_hold_rdy", {71'b0, cpkt_rdy}, 72'd0);
      chk("rd0_hold_data", rpkt_data, {32'h1234_5678, 32'hFFFF_FE03, 8'h02});
    end
    chk("rd0_parity_odd", {71'b0, ^rpkt_data}, 72'd1);
    rpkt_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("rd0_release_vld", {71'b0, rpkt_vld}, 72'd0);
    chk("rd0_release_rdy", {71'b0, cpkt_rdy}, 72'd1);
    @(negedge clk);

    // Rejections: bad opcode, then a write without payload
    send(mk(4'h7, 1'b1, 32'h0000_0005));
    @(negedge clk);
    @(negedge clk);
    chk("rej_cmd7_err", {64'b0, err_cnt}, 72'd1);
    send(mk(4'h1, 1'b0, 32'h0000_0005));
    @(negedge clk);
    @(negedge clk);
    chk("rej_nopld_err", {64'b0, err_cnt}, 72'd2);
    chk("rej_nopld_mode", {68'b0, mode}, 72'd0);
    chk("rej_no_reply", {71'b0, rpkt_vld}, 72'd0);

    for (int i = 0; i < 300; i++) send(mk(4'hF, 1'b1, 32'h0));
    @(negedge clk);
    @(negedge clk);
    chk("err_saturate", {64'b0, err_cnt}, 72'hFF);

    // Back-to-back with vld held high: accepts on cycles 0, 2, 4
    cpkt_data = mk(4'h2, 1'b1, 32'h0000_0001);
    cpkt_vld  = 1'b1;
    chk("b2b_c0_rdy", {71'b0, cpkt_rdy}, 72'd1);
    @(negedge clk);
    chk("b2b_c1_rdy", {71'b0, cpkt_rdy}, 72'd0);
    cpkt_data = mk(4'h1, 1'b1, 32'hFFFF_FFFA);
    @(negedge clk);
    chk("b2b_c2_rdy", {71'b0, cpkt_rdy}, 72'd1);
    chk("b2b_enable", {71'b0, enable}, 72'd1);
    @(negedge clk);
    chk("b2b_c3_rdy", {71'b0, cpkt_rdy}, 72'd0);
    cpkt_data = mk(4'h3, 1'b1, 32'h0000_0001);
    @(negedge clk);
    chk("b2b_c4_rdy", {71'b0, cpkt_rdy}, 72'd1);
    chk("b2b_mode", {68'b0, mode}, 72'hA);
    @(negedge clk);
    cpkt_vld = 1'b0;
    @(negedge clk);
    chk("b2b_rd_vld", {71'b0, rpkt_vld}, 72'd1);
    chk("b2b_rd_data", rpkt_data, {32'h0000_000A, 32'hFFFF_FE03, 8'h03});
    @(negedge clk);
    chk("b2b_rd_done", {71'b0, rpkt_vld}, 72'd0);

    // RD enable and RD err_cnt
    send(mk(4'h3, 1'b1, 32'h0000_0002));
    @(negedge clk);
    @(negedge clk);
    chk("rd_en_data", rpkt_data, {32'h0000_0001, 32'hFFFF_FE03, 8'h02});
    @(negedge clk);
    send(mk(4'h3, 1'b1, 32'h0000_0003));
    @(negedge clk);
    @(negedge clk);
    chk("rd_err_data", rpkt_data, {32'h0000_00FF, 32'hFFFF_FE03, 8'h03});
    chk("rd_err_unchanged", {64'b0, err_cnt}, 72'hFF);
    @(negedge clk);

    // Reset asserted while a reply is pending
    rpkt_rdy = 1'b0;
    send(mk(4'h3, 1'b1, 32'h0000_0000));
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_pre_vld", {71'b0, rpkt_vld}, 72'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", {71'b0, rpkt_vld}, 72'd0);
    chk("mid_rst_data", rpkt_data, 72'd0);
    chk("mid_rst_vkey", {40'b0, vkey}, 72'h0200_0000);
    chk("mid_rst_mode", {68'b0, mode}, 72'd0);
    chk("mid_rst_enable", {71'b0, enable}, 72'd0);
    chk("mid_rst_err", {64'b0, err_cnt}, 72'd0);
    chk("mid_rst_busy", {71'b0, busy}, 72'd0);
    chk("mid_rst_rdy", {71'b0, cpkt_rdy}, 72'd0);
    @(negedge clk);
    rst = 1'b1;
    send(mk(4'h0, 1'b1, 32'hCAFE_F00D));
    @(negedge clk);
    @(negedge clk);
    chk("post_mid_rst_vkey", {40'b0, vkey}, 72'hCAFE_F00D);
    chk("post_mid_rst_no_reply", {71'b0, rpkt_vld}, 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
